// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt sequencer.
// Holds FSM state encoding, source indices and vector addresses.
package int_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [2:0] SRC_INT0 = 3'd0;
    localparam logic [2:0] SRC_T0   = 3'd1;
    localparam logic [2:0] SRC_INT1 = 3'd2;
    localparam logic [2:0] SRC_T1   = 3'd3;
    localparam logic [2:0] SRC_SER  = 3'd4;

    localparam logic [15:0] VEC_INT0 = 16'h0003;
    localparam logic [15:0] VEC_T0   = 16'h000B;
    localparam logic [15:0] VEC_INT1 = 16'h0013;
    localparam logic [15:0] VEC_T1   = 16'h001B;
    localparam logic [15:0] VEC_SER  = 16'h0023;

    function automatic logic [15:0] vec_of(input logic [2:0] src);
        logic [15:0] v;
        v = 16'h0000;
        unique case (src)
            SRC_INT0: v = VEC_INT0;
            SRC_T0:   v = VEC_T0;
            SRC_INT1: v = VEC_INT1;
            SRC_T1:   v = VEC_T1;
            SRC_SER:  v = VEC_SER;
            default:  v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/int_isr_stack.sv
// Two-level in-service tracker for the interrupt sequencer.
// RETI retires the highest active level before an ack adds its level.
module int_isr_stack
    import int_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       push_lvl,
    input  logic       reti,
    output logic [1:0] in_service
);

    logic [1:0] ins_nxt;

    always_comb begin
        ins_nxt = in_service;
        if (reti) begin
            if (ins_nxt[1]) begin
                ins_nxt[1] = 1'b0;
            end else begin
                ins_nxt[0] = 1'b0;
            end
        end
        if (push) begin
            ins_nxt[push_lvl] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_service <= 2'b00;
        end else begin
            in_service <= ins_nxt;
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// 8051-style interrupt sequencer: polls the arbiter winner at
// instruction boundaries, requests an LCALL and tracks nesting.
module int_sequencer
    import int_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  int_early,
    input  logic [4:0]  ip,
    input  logic        instr_boundary,
    input  logic        ack,
    input  logic        reti,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic [3:0]  clr_flag,
    output logic [1:0]  in_service
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] src_idx;
    logic       src_lvl;
    logic [2:0] src_q;
    logic       lvl_q;
    logic       level_ok;
    logic       accept;
    logic       take;
    logic [3:0] clr_nxt;

    always_comb begin
        src_idx = SRC_INT0;
        unique case (1'b1)
            int_early[0]: src_idx = SRC_INT0;
            int_early[1]: src_idx = SRC_T0;
            int_early[2]: src_idx = SRC_INT1;
            int_early[3]: src_idx = SRC_T1;
            int_early[4]: src_idx = SRC_SER;
            default:      src_idx = SRC_INT0;
        endcase
    end

    assign src_lvl  = |(int_early & ip);
    assign level_ok = src_lvl ? !in_service[1]
                              : (in_service == 2'b00);

    // No vectoring in the RETI cycle: one more instruction must run.
    assign accept = (state == IDLE) && instr_boundary
                 && (|int_early) && !reti && level_ok;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        clr_nxt   = 4'b0000;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = IDLE;
                    take      = 1'b1;
                    if (src_q != SRC_SER) begin
                        clr_nxt[src_q[1:0]] = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_q    <= 3'd0;
            lvl_q    <= 1'b0;
            clr_flag <= 4'b0000;
        end else begin
            state    <= state_nxt;
            clr_flag <= clr_nxt;
            if (accept) begin
                src_q <= src_idx;
                lvl_q <= src_lvl;
            end
        end
    end

    assign int_req    = (state == REQ);
    assign int_vector = int_req ? vec_of(src_q) : 16'h0000;

    int_isr_stack u_isr (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (take),
        .push_lvl   (lvl_q),
        .reti       (reti),
        .in_service (in_service)
    );

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: directed scenarios plus random
// traffic checked against a stack-based model of interrupt nesting.
module tb_int_sequencer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  int_early;
    logic [4:0]  ip;
    logic        instr_boundary;
    logic        ack;
    logic        reti;
    logic        int_req;
    logic [15:0] int_vector;
    logic [3:0]  clr_flag;
    logic [1:0]  in_service;

    int_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .int_early      (int_early),
        .ip             (ip),
        .instr_boundary (instr_boundary),
        .ack            (ack),
        .reti           (reti),
        .int_req        (int_req),
        .int_vector     (int_vector),
        .clr_flag       (clr_flag),
        .in_service     (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [15:0] vec;
        logic [3:0]  clr;
        logic [1:0]  ins;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: stack of active levels (0 low, 1 high), pending request
    int   stk[$];
    bit   m_pend;
    int   m_src;
    int   m_lvl;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".int_req"}, {15'd0, int_req}, {15'd0, e.req});
            chk({e.tag, ".int_vector"}, int_vector, e.vec);
            chk({e.tag, ".clr_flag"}, {12'd0, clr_flag}, {12'd0, e.clr});
            chk({e.tag, ".in_service"}, {14'd0, in_service},
                {14'd0, e.ins});
        end
    end

    function automatic logic [1:0] model_ins();
        logic [1:0] r;
        r = 2'b00;
        foreach (stk[i]) r[stk[i]] = 1'b1;
        return r;
    endfunction

    function automatic int model_cur();
        int c;
        c = -1;
        foreach (stk[i]) if (stk[i] > c) c = stk[i];
        return c;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_pend = 1'b0;
        m_src  = 0;
        m_lvl  = 0;
    endtask

    // Drive one cycle at the falling edge and queue the expected result.
    task automatic cyc(input logic [4:0] e, input logic [4:0] p,
                       input logic b, input logic a, input logic r,
                       input string tag);
        exp_t x;
        int   idx;
        int   slvl;
        bit   accept;
        bit   ack_eff;
        int_early      = e;
        ip             = p;
        instr_boundary = b;
        ack            = a;
        reti           = r;
        idx = 0;
        for (int i = 0; i < 5; i++) if (e[i]) idx = i;
        slvl    = p[idx];
        accept  = !m_pend && b && (e != 0) && !r && (slvl > model_cur());
        ack_eff = m_pend && a;
        x.clr   = 4'b0000;
        if (ack_eff && m_src < 4) x.clr[m_src] = 1'b1;
        if (r && stk.size() > 0) void'(stk.pop_back());
        if (ack_eff) begin
            stk.push_back(m_lvl);
            m_pend = 1'b0;
        end
        if (accept) begin
            m_pend = 1'b1;
            m_src  = idx;
            m_lvl  = slvl;
        end
        x.req = m_pend;
        x.vec = m_pend ? 16'(3 + 8 * m_src) : 16'h0000;
        x.ins = model_ins();
        x.tag = tag;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [4:0] e;
        model_reset();
        rst_n = 1'b0;
        int_early = 0; ip = 0; instr_boundary = 0; ack = 0; reti = 0;
        #12;
        chk("reset.int_req", {15'd0, int_req}, 16'd0);
        chk("reset.int_vector", int_vector, 16'h0000);
        chk("reset.clr_flag", {12'd0, clr_flag}, 16'd0);
        chk("reset.in_service", {14'd0, in_service}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T0 low-level request and ack
        cyc(5'b00010, 5'd0, 1, 0, 0, "t0_req");
        cyc(5'b00000, 5'd0, 0, 1, 0, "t0_ack");
        idle("t0_idle");
        // INT1 high nests over low
        cyc(5'b00100, 5'b00100, 1, 0, 0, "int1_req");
        cyc(5'b00000, 5'd0, 0, 1, 0, "int1_ack");
        idle("int1_idle");
        // low-level INT1 refused while low active
        cyc(5'b00100, 5'd0, 1, 0, 0, "int1_low_ref");
        idle("int1_low_ref2");
        // RETI unwinding
        cyc(5'd0, 5'd0, 0, 0, 1, "reti1");
        cyc(5'd0, 5'd0, 0, 0, 1, "reti2");
        cyc(5'd0, 5'd0, 0, 0, 1, "reti3");
        // RETI blocks same-cycle poll
        cyc(5'b00001, 5'd0, 1, 0, 0, "int0_req");
        cyc(5'd0, 5'd0, 0, 1, 0, "int0_ack");
        cyc(5'b00001, 5'd0, 1, 0, 1, "reti_block");
        cyc(5'b00001, 5'd0, 1, 0, 0, "after_reti");
        cyc(5'd0, 5'd0, 0, 1, 0, "after_reti_ack");
        cyc(5'd0, 5'd0, 0, 0, 1, "reti4");
        // serial held after drop, no flag clear
        cyc(5'b10000, 5'd0, 1, 0, 0, "ser_req");
        cyc(5'b00000, 5'd0, 1, 0, 0, "ser_hold");
        cyc(5'b01000, 5'b01000, 1, 0, 0, "ser_hold2");
        cyc(5'd0, 5'd0, 0, 1, 0, "ser_ack");
        cyc(5'd0, 5'd0, 0, 1, 0, "ack_idle");
        cyc(5'd0, 5'd0, 0, 0, 1, "reti5");

        // reset mid-request
        cyc(5'b01000, 5'b01000, 1, 0, 0, "t1_req");
        idle("t1_wait");
        rst_n = 1'b0;
        #1;
        chk("midreset.int_req", {15'd0, int_req}, 16'd0);
        chk("midreset.int_vector", int_vector, 16'h0000);
        chk("midreset.in_service", {14'd0, in_service}, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5'd0, 5'd0, 0, 1, 0, "post_reset_ack");
        idle("post_reset_idle");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) e = 5'd0;
            else e = 5'(1 << $urandom_range(0, 4));
            cyc(e, 5'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 5) == 0), "rand");
        end
        idle("drain");
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
